// File: rtl/fixed_point_pkg.sv
// Shared signed fixed-point definitions: default component width, lane count
// and the saturation limits used by the per-lane adders.
package fixed_point_pkg;

  localparam int FP_WIDTH  = 32;
  localparam int DEF_LANES = 3;

  typedef logic [FP_WIDTH-1:0] fixed_point_t;

  localparam fixed_point_t FP_SAT_MAX = 32'h7FFF_FFFF;
  localparam fixed_point_t FP_SAT_MIN = 32'h8000_0000;

  // 64-bit limits so narrower widths can take their top WIDTH bits.
  localparam logic [63:0] FP_SAT_MAX_64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FP_SAT_MIN_64 = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/vector_addsub_pipe_pkg.sv
// Vector packing for the add/sub pipe: lane 0 (x) sits in the MSBs.
package vector_addsub_pipe_pkg;
  import fixed_point_pkg::*;

  typedef logic [DEF_LANES*FP_WIDTH-1:0] vec_t;
  typedef logic [DEF_LANES-1:0]          lane_mask_t;

  function automatic int lane_lsb(input int lane, input int lanes, input int width);
    return (lanes - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/fixed_point_addsub_sat.sv
// One lane of signed two's-complement add/sub with optional saturation.
module fixed_point_addsub_sat
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
) (
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             mode_i,
  input  logic             saturate_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] SAT_MAX = FP_SAT_MAX_64[63 -: WIDTH];
  localparam logic [WIDTH-1:0] SAT_MIN = FP_SAT_MIN_64[63 -: WIDTH];

  logic [WIDTH-1:0] op2_eff;
  logic [WIDTH-1:0] raw;

  assign op2_eff    = mode_i ? ~op2_i : op2_i;
  assign raw        = op1_i + op2_eff + {{(WIDTH-1){1'b0}}, mode_i};
  assign overflow_o = (op1_i[WIDTH-1] == op2_eff[WIDTH-1]) && (raw[WIDTH-1] != op1_i[WIDTH-1]);

  // Overflow direction always follows op1's sign.
  always_comb begin
    result_o = raw;
    if (saturate_i && overflow_o) begin
      result_o = op1_i[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/vector_addsub_pipe.sv
// Pipelined vector add/sub: arithmetic in stage 1, pure delay stages after,
// global stall enable, per-lane overflow and a sticky overflow status bit.
module vector_addsub_pipe
  import fixed_point_pkg::*;
  import vector_addsub_pipe_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int WIDTH   = FP_WIDTH,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] op1,
  input  logic [LANES*WIDTH-1:0] op2,
  input  logic                   mode,
  input  logic                   saturate,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       lane_overflow,
  output logic                   overflow,
  input  logic                   clr_sticky,
  output logic                   overflow_sticky
);

  localparam int VW = LANES * WIDTH;

  logic             en;
  logic [VW-1:0]    data_d;
  logic [LANES-1:0] lovf_d;
  logic             valid_q [LATENCY];
  logic [VW-1:0]    data_q  [LATENCY];
  logic [LANES-1:0] lovf_q  [LATENCY];
  logic             sticky_d, sticky_q;

  assign en       = !valid_q[LATENCY-1] || out_ready;
  assign in_ready = en;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int LSB = lane_lsb(l, LANES, WIDTH);
    fixed_point_addsub_sat #(.WIDTH(WIDTH)) u_lane (
      .op1_i      (op1[LSB +: WIDTH]),
      .op2_i      (op2[LSB +: WIDTH]),
      .mode_i     (mode),
      .saturate_i (saturate),
      .result_o   (data_d[LSB +: WIDTH]),
      .overflow_o (lovf_d[LANES-1-l])
    );
  end

  // Bubbles travel like beats, so stage-1 valid simply follows in_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        lovf_q[s]  <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      data_q[0]  <= data_d;
      lovf_q[0]  <= lovf_d;
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        data_q[s]  <= data_q[s-1];
        lovf_q[s]  <= lovf_q[s-1];
      end
    end
  end

  assign out_valid     = valid_q[LATENCY-1];
  assign result        = data_q[LATENCY-1];
  assign lane_overflow = out_valid ? lovf_q[LATENCY-1] : '0;
  assign overflow      = |lane_overflow;

  // Set wins over clear when both happen on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (out_valid && out_ready && overflow) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign overflow_sticky = sticky_q;

endmodule

// File: doc/vector_addsub_pipe.md
VECTOR_ADDSUB_PIPE -- requirements
Module: vector_addsub_pipe

Interface
REQ-001 SHALL have parameter LANES, default 3, number of vector components (x,y,z order, lane 0 = x, packed MSB-first).
REQ-002 SHALL have parameter WIDTH, default 32, bit width of one signed fixed-point component (fixed_point_t width).
REQ-003 SHALL have parameter LATENCY, default 2, pipeline register stages from input accept to output valid; legal range 1..4.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat.
REQ-008 SHALL have port op1  input  LANES*WIDTH  first operand vector.
REQ-009 SHALL have port op2  input  LANES*WIDTH  second operand vector.
REQ-010 SHALL have port mode  input  1  0 = op1+op2, 1 = op1-op2; sampled with beat.
REQ-011 SHALL have port saturate  input  1  1 = clamp on overflow, 0 = wrap; sampled with beat.
REQ-012 SHALL have port out_valid  output  1  result beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port result  output  LANES*WIDTH  per-lane result.
REQ-015 SHALL have port lane_overflow  output  LANES  per-lane overflow flag of the current result beat.
REQ-016 SHALL have port overflow  output  1  OR of lane_overflow.
REQ-017 SHALL have port clr_sticky  input  1  clear sticky overflow status.
REQ-018 SHALL have port overflow_sticky  output  1  set by any delivered beat with overflow.

Function
REQ-019 SHALL accept a beat when in_valid && in_ready; SHALL deliver when out_valid && out_ready.
REQ-020 SHALL advance all stages together on enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational from out_ready, no path from in_valid).
REQ-021 SHALL present an accepted beat on out_valid exactly LATENCY cycles after acceptance when no stall occurs; stalls SHALL hold every stage, bubbles are not compressed.
REQ-022 SHALL hold result, lane_overflow, overflow stable while out_valid && !out_ready.
REQ-023 SHALL compute each lane in two's complement at WIDTH bits; subtraction as op1 + ~op2 + 1.
REQ-024 SHALL flag lane overflow when operands (op2 inverted for sub) share a sign and the raw result sign differs; op2 = most-negative in sub mode SHALL overflow iff op1 >= 0.
REQ-025 SHALL, with saturate=1 and overflow, output max positive (0x7FFF_FFFF at WIDTH=32) if op1 >= 0, else most negative (0x8000_0000); lane_overflow still set.
REQ-026 SHALL, with saturate=0, output wrapped WIDTH-bit result with lane_overflow set.
REQ-027 SHALL compute arithmetic in stage 1; stages 2..LATENCY SHALL be pure delay registers.
REQ-028 SHALL set overflow_sticky on the clock edge delivering a beat with overflow=1; clr_sticky SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-029 SHALL drive lane_overflow/overflow to 0 whenever out_valid=0.

Reset
REQ-030 SHALL on reset clear all stage valid bits, out_valid=0, overflow_sticky=0, result=0, lane_overflow=0, independent of clk.
REQ-031 SHALL discard in-flight beats on reset mid-operation; in_ready SHALL be 1 after reset release.

Structure
REQ-032 SHALL place WIDTH default, lane count default and saturation limit constants in the shared fixed_point package; vector packing typedefs in the vector package.
REQ-033 SHALL use one sub-module fixed_point_addsub_sat (one lane: mode, saturate, result, overflow), instantiated LANES times via generate.

Verification
REQ-034 Defaults, mode=0, op1 lanes (1,2,3), op2 (4,5,6), out_ready=1 -> result (5,7,9), overflow=0, out_valid 2 cycles after accept.
REQ-035 mode=1, saturate=0, lane0 op1=0x7FFF_FFFF, op2=0xFFFF_FFFF -> lane0 0x8000_0000, lane_overflow=3'b100, overflow_sticky=1 after delivery.
REQ-036 Same as REQ-035 with saturate=1 -> lane0 0x7FFF_FFFF, lane_overflow=3'b100.
REQ-037 Stream 4 beats, out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, results held, all 4 delivered in order, none lost/duplicated.
REQ-038 Assert reset with 2 beats in flight -> out_valid=0 immediately, no beat delivered afterwards, overflow_sticky=0.
REQ-039 overflow beat delivered in same cycle as clr_sticky=1 -> overflow_sticky=1; clr_sticky next cycle alone -> 0.
